// File: rtl/wdm_pkg.sv
// Shared types and defaults for the WDM receive-path wavelength-lock blocks.
package wdm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCUM,
    EVAL,
    DONE
  } sweep_state_e;

  localparam int DefaultSettleCycles = 16;
  localparam int DefaultNumAvg       = 4;

endpackage

// File: rtl/pd_sample_avg.sv
// Real-valued accumulator: sums one photodetector sample per enable and
// presents the running sum divided by NumAvg.
module pd_sample_avg #(
  parameter int NumAvg = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  real  sample,
  output real  avg,
  output logic count_done
);

  localparam int CntW = $clog2(NumAvg) + 1;

  real            sum;
  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 0.0;
      cnt <= '0;
    end else if (clear) begin
      sum <= 0.0;
      cnt <= '0;
    end else if (en) begin
      sum <= sum + sample;
      cnt <= cnt + 1'b1;
    end
  end

  // Flags the enable that completes the set, so the caller leaves ACCUM
  // on the same edge that captures the last sample.
  assign count_done = en && !clear && (cnt == CntW'(NumAvg - 1));
  assign avg        = sum / real'(NumAvg);

endmodule

// File: rtl/pd_sweep_ctrl.sv
// Heater code sweep sequencer: settle, average photodetector current,
// and track the code giving the peak average current.
module pd_sweep_ctrl
  import wdm_pkg::*;
#(
  parameter int CodeWidth    = 8,
  parameter int SettleCycles = DefaultSettleCycles,
  parameter int NumAvg       = DefaultNumAvg
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CodeWidth-1:0] i_code_min,
  input  logic [CodeWidth-1:0] i_code_max,
  input  logic [CodeWidth-1:0] i_code_step,
  input  real                  i_real_current,
  output logic [CodeWidth-1:0] o_heater_code,
  output logic                 o_busy,
  output logic                 o_sample_valid,
  output real                  o_real_sample_avg,
  output logic                 o_done,
  output logic [CodeWidth-1:0] o_peak_code,
  output real                  o_real_peak_current
);

  localparam int SetW = $clog2(SettleCycles) + 1;

  sweep_state_e         state;
  sweep_state_e         next_state;
  logic [SetW-1:0]      settle_cnt;
  logic [CodeWidth-1:0] max_q;
  logic [CodeWidth-1:0] step_q;
  logic [CodeWidth:0]   next_code;
  logic                 accum_en;
  logic                 avg_clear;
  logic                 count_done;

  pd_sample_avg #(
    .NumAvg(NumAvg)
  ) u_avg (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (avg_clear),
    .en        (accum_en),
    .sample    (i_real_current),
    .avg       (o_real_sample_avg),
    .count_done(count_done)
  );

  // One extra bit so stepping past the top of the code range terminates
  // instead of wrapping back to a low code.
  assign next_code = {1'b0, o_heater_code} + {1'b0, step_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    accum_en   = 1'b0;
    avg_clear  = 1'b0;
    case (state)
      IDLE: begin
        avg_clear = 1'b1;
        if (i_start) next_state = (i_code_min > i_code_max) ? DONE : SETTLE;
      end
      SETTLE: if (settle_cnt == SetW'(SettleCycles - 1)) next_state = ACCUM;
      ACCUM: begin
        accum_en = 1'b1;
        if (count_done) next_state = EVAL;
      end
      EVAL: begin
        avg_clear  = 1'b1;
        next_state = (next_code > {1'b0, max_q}) ? DONE : SETTLE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (state != IDLE && i_abort) begin
      next_state = IDLE;
      accum_en   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) settle_cnt <= '0;
    else          settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_heater_code       <= '0;
      max_q               <= '0;
      step_q              <= '0;
      o_peak_code         <= '0;
      o_real_peak_current <= 0.0;
    end else if (state == IDLE && i_start) begin
      o_heater_code       <= i_code_min;
      max_q               <= i_code_max;
      step_q              <= (i_code_step == '0) ? CodeWidth'(1) : i_code_step;
      o_peak_code         <= i_code_min;
      o_real_peak_current <= 0.0;
    end else if (state == EVAL && !i_abort) begin
      // Strict compare keeps the lower code on equal averages.
      if (o_real_sample_avg > o_real_peak_current) begin
        o_real_peak_current <= o_real_sample_avg;
        o_peak_code         <= o_heater_code;
      end
      if (next_state == SETTLE) o_heater_code <= next_code[CodeWidth-1:0];
    end
  end

  assign o_busy         = (state != IDLE);
  assign o_sample_valid = (state == EVAL);
  assign o_done         = (state == DONE);

endmodule

// File: tb/tb_pd_sweep_ctrl.sv
// Closed-loop bench: a per-code current table stands in for the ring and
// photodetector; a sweep model predicts codes, averages, timing and peak.
module tb_pd_sweep_ctrl;

  localparam int PointCycles = 16 + 4 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [7:0] i_code_min = '0;
  logic [7:0] i_code_max = '0;
  logic [7:0] i_code_step = '0;
  real        i_real_current = 0.0;
  logic [7:0] o_heater_code;
  logic       o_busy;
  logic       o_sample_valid;
  real        o_real_sample_avg;
  logic       o_done;
  logic [7:0] o_peak_code;
  real        o_real_peak_current;

  real cur_table [256];
  int  errors = 0;
  int  checks = 0;

  pd_sweep_ctrl dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_start            (i_start),
    .i_abort            (i_abort),
    .i_code_min         (i_code_min),
    .i_code_max         (i_code_max),
    .i_code_step        (i_code_step),
    .i_real_current     (i_real_current),
    .o_heater_code      (o_heater_code),
    .o_busy             (o_busy),
    .o_sample_valid     (o_sample_valid),
    .o_real_sample_avg  (o_real_sample_avg),
    .o_done             (o_done),
    .o_peak_code        (o_peak_code),
    .o_real_peak_current(o_real_peak_current)
  );

  always #5 clk = ~clk;

  // Ring response tracks whatever code the heater is currently driven with.
  always #1 i_real_current = cur_table[o_heater_code];

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_real(input string tag, input real obs, input real exp);
    checks++;
    assert (((obs - exp) < 1.0e-9) && ((exp - obs) < 1.0e-9))
    else begin
      errors++;
      $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    end
  endtask

  task automatic fill_ring(input int center);
    for (int c = 0; c < 256; c++)
      cur_table[c] = 1.0 - 0.1 * real'((c > center) ? c - center : center - c);
  endtask

  task automatic fill_const(input real v);
    for (int c = 0; c < 256; c++) cur_table[c] = v;
  endtask

  task automatic fill_random();
    for (int c = 0; c < 256; c++) cur_table[c] = real'($urandom_range(0, 255)) / 16.0;
  endtask

  // Presents a start at the current negedge; it is taken on the next posedge.
  task automatic apply_stimulus(input int mn, input int mx, input int st);
    i_code_min  = 8'(mn);
    i_code_max  = 8'(mx);
    i_code_step = 8'(st);
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Runs one sweep from a negedge in IDLE and checks it against the model.
  task automatic check_output(input string name, input int mn, input int mx,
                              input int st, input bit poke_busy);
    int  codes[$];
    int  st_eff;
    int  exp_pk;
    real exp_peak;
    int  cyc;
    int  k;
    bit  got_done;

    st_eff = (st == 0) ? 1 : st;
    if (mn <= mx)
      for (int c = mn; c <= mx; c += st_eff) codes.push_back(c);
    exp_peak = 0.0;
    exp_pk   = mn;
    foreach (codes[i])
      if (cur_table[codes[i]] > exp_peak) begin
        exp_peak = cur_table[codes[i]];
        exp_pk   = codes[i];
      end

    apply_stimulus(mn, mx, st);
    cyc      = 1;
    k        = 0;
    got_done = 1'b0;
    while (cyc <= PointCycles * codes.size() + 8 && !got_done) begin
      if (o_sample_valid) begin
        if (k < codes.size()) begin
          check_int({name, " code"}, int'(o_heater_code), codes[k]);
          check_real({name, " avg"}, o_real_sample_avg, cur_table[codes[k]]);
        end
        check_int({name, " valid_cycle"}, cyc, PointCycles * (k + 1));
        k++;
      end
      if (o_done) begin
        got_done = 1'b1;
        check_int({name, " done_cycle"}, cyc, PointCycles * codes.size() + 1);
        check_int({name, " peak_code"}, int'(o_peak_code), exp_pk);
        check_real({name, " peak"}, o_real_peak_current, exp_peak);
        i_code_min = 8'd1;
        i_code_max = 8'd2;
        i_start    = 1'b1;
      end else begin
        if (poke_busy && cyc == 30) begin
          i_code_min  = 8'd0;
          i_code_max  = 8'd200;
          i_code_step = 8'd1;
          i_start     = 1'b1;
        end else begin
          i_start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) check_int({name, " done_timeout"}, 0, 1);
    check_int({name, " points"}, k, codes.size());
    @(negedge clk);
    i_start = 1'b0;
    check_int({name, " idle_after_done"}, int'(o_busy), 0);
    check_int({name, " single_done"}, int'(o_done), 0);
  endtask

  initial begin
    fill_const(0.0);

    // Reset values while held in reset.
    #12;
    check_int("rst code", int'(o_heater_code), 0);
    check_int("rst busy", int'(o_busy), 0);
    check_int("rst valid", int'(o_sample_valid), 0);
    check_int("rst done", int'(o_done), 0);
    check_int("rst peak_code", int'(o_peak_code), 0);
    check_real("rst peak", o_real_peak_current, 0.0);
    check_real("rst avg", o_real_sample_avg, 0.0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    fill_ring(12);
    check_output("ring", 10, 14, 2, 1'b0);

    fill_const(0.5);
    check_output("tie_step0", 3, 5, 0, 1'b0);

    fill_ring(252);
    check_output("top", 250, 255, 4, 1'b0);

    fill_random();
    check_output("min_gt_max", 20, 10, 1, 1'b0);

    fill_ring(12);
    check_output("busy_start", 10, 14, 2, 1'b1);

    // Abort in the ACCUM phase of the second code point.
    apply_stimulus(10, 14, 2);
    for (int c = 1; c < PointCycles + 18; c++) begin
      check_int("abort no_early_done", int'(o_done), 0);
      @(negedge clk);
    end
    check_int("abort busy_before", int'(o_busy), 1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check_int("abort busy", int'(o_busy), 0);
    check_int("abort done", int'(o_done), 0);
    check_int("abort code_hold", int'(o_heater_code), 12);
    fill_ring(30);
    check_output("after_abort", 28, 32, 1, 1'b0);

    // Asynchronous reset in the middle of a sweep.
    apply_stimulus(10, 14, 2);
    repeat (25) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_int("async_rst busy", int'(o_busy), 0);
    check_int("async_rst code", int'(o_heater_code), 0);
    check_int("async_rst peak_code", int'(o_peak_code), 0);
    check_real("async_rst peak", o_real_peak_current, 0.0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      int mn;
      int mx;
      fill_random();
      mn = int'($urandom_range(0, 255));
      mx = (r == 3) ? int'($urandom_range(0, 255)) : mn + int'($urandom_range(0, 30));
      if (mx > 255) mx = 255;
      check_output("random", mn, mx, int'($urandom_range(0, 7)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
